// File: rtl/trace_capture_if.sv
`default_nettype none
// ============================================================================
// Module  : trace_capture_if
// Brief   : Probe, trigger, control and readout bundle for trace_capture.
//           rd_data widens by TS_W when TRACE_TIMESTAMP_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
interface trace_capture_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int TS_W  = 8
);
`ifdef TRACE_TIMESTAMP_EN
  localparam int TS_EN = 1;
`else
  localparam int TS_EN = 0;
`endif
  localparam int RD_W = WIDTH + TS_EN * TS_W;
  localparam int CW   = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] probe;
  logic             arm;
  logic             clear;
  logic             mode;
  logic [WIDTH-1:0] trig_mask;
  logic [WIDTH-1:0] trig_value;
  logic             rd_req;
  logic [RD_W-1:0]  rd_data;
  logic             rd_valid;
  logic [1:0]       state;
  logic [CW-1:0]    count;

  modport master (
    output probe, arm, clear, mode, trig_mask, trig_value, rd_req,
    input  rd_data, rd_valid, state, count
  );

  modport slave (
    input  probe, arm, clear, mode, trig_mask, trig_value, rd_req,
    output rd_data, rd_valid, state, count
  );
endinterface
`default_nettype wire

// File: rtl/trace_capture.sv
`default_nettype none
// ============================================================================
// Module  : trace_capture
// Brief   : Logic-analyser capture of a probe bus into a circular buffer around
//           a masked-match trigger, with oldest-first readout once DONE.
//           Optional macro TRACE_TIMESTAMP_EN adds a per-entry cycle stamp.
// Rev     : 1.0  initial release
// ============================================================================
module trace_capture #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int POST  = 4,
  parameter int TS_W  = 8
) (
  input  logic            clk,
  input  logic            rst,
  trace_capture_if.slave  bus
);
`ifdef TRACE_TIMESTAMP_EN
  localparam int TS_EN = 1;
`else
  localparam int TS_EN = 0;
`endif
  localparam int RD_W = WIDTH + TS_EN * TS_W;
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] POST_N = CW'(POST);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           state_q,    state_d;
  logic [AW-1:0]    wr_ptr_q,   wr_ptr_d;
  logic [CW-1:0]    count_q,    count_d;
  logic [CW-1:0]    post_q,     post_d;
  logic [CW-1:0]    rd_idx_q,   rd_idx_d;
  logic             first_q,    first_d;
  logic [WIDTH-1:0] prev_q,     prev_d;
  logic [RD_W-1:0]  rd_data_q,  rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  logic [RD_W-1:0]  mem_q [DEPTH];
  logic             we;
  logic             trig;
  logic [RD_W-1:0]  wdata;
  logic [AW-1:0]    rd_addr;

  assign trig = ((bus.probe ^ bus.trig_value) & bus.trig_mask) == '0;

  // Oldest entry sits at wr_ptr once the buffer is full, otherwise at 0.
  assign rd_addr = ((count_q == FULL) ? wr_ptr_q : '0) + rd_idx_q[AW-1:0];

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;

  always_comb begin
    ts_d = ts_q;
    if (!bus.clear) begin
      if (bus.arm)
        ts_d = '0;
      else if (state_q == S_ARMED || state_q == S_CAPTURE)
        ts_d = ts_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_d;
  end

  assign wdata = {ts_q, bus.probe};
`else
  assign wdata = bus.probe;
`endif

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    post_d     = post_q;
    rd_idx_d   = rd_idx_q;
    first_d    = first_q;
    prev_d     = bus.probe;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    we         = 1'b0;

    if (bus.clear) begin
      state_d = S_IDLE;
      count_d = '0;
    end else if (bus.arm) begin
      state_d  = S_ARMED;
      wr_ptr_d = '0;
      count_d  = '0;
      post_d   = '0;
      rd_idx_d = '0;
      first_d  = 1'b1;
    end else begin
      unique case (state_q)
        S_ARMED, S_CAPTURE: begin
          first_d = 1'b0;
          // The triggering sample is stored even when mode 1 sees no change.
          we = !bus.mode || first_q || (bus.probe != prev_q) ||
               (state_q == S_ARMED && trig);
          if (we) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (count_q != FULL)
              count_d = count_q + 1'b1;
            if (state_q == S_ARMED) begin
              if (trig) begin
                post_d  = CW'(1);
                state_d = (POST == 1) ? S_DONE : S_CAPTURE;
              end
            end else begin
              post_d = post_q + 1'b1;
              if (post_q + 1'b1 == POST_N)
                state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          if (bus.rd_req && (rd_idx_q < count_q)) begin
            rd_data_d  = mem_q[rd_addr];
            rd_valid_d = 1'b1;
            rd_idx_d   = rd_idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      post_q     <= '0;
      rd_idx_q   <= '0;
      first_q    <= 1'b0;
      prev_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      post_q     <= post_d;
      rd_idx_q   <= rd_idx_d;
      first_q    <= first_d;
      prev_q     <= prev_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst)
      mem_q[wr_ptr_q] <= wdata;
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.state    = state_q;
  assign bus.count    = count_q;
endmodule
`default_nettype wire

// File: tb/tb_trace_capture.sv
`default_nettype none
// ============================================================================
// Module  : tb_trace_capture
// Brief   : Scenario tasks plus randomized traffic against a queue-based model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_trace_capture;
  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int POST  = 4;
  localparam int TS_W  = 8;
`ifdef TRACE_TIMESTAMP_EN
  localparam int TS_EN = 1;
`else
  localparam int TS_EN = 0;
`endif
  localparam int RD_W = WIDTH + TS_EN * TS_W;
  localparam int CW   = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  trace_capture_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TS_W(TS_W)) bus ();

  trace_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .POST(POST), .TS_W(TS_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: list of stored samples, oldest first, capped at DEPTH.
  int              m_state;
  logic [RD_W-1:0] m_q[$];
  int              m_post;
  bit              m_first;
  logic [WIDTH-1:0] m_prev;
  int              m_ts;
  int              m_rd_idx;
  bit              m_valid;
  logic [RD_W-1:0] m_data;

  function automatic logic [RD_W-1:0] entry(input int ts, input logic [WIDTH-1:0] p);
    logic [WIDTH+TS_W-1:0] full;
    full = {TS_W'(ts), p};
    return full[RD_W-1:0];
  endfunction

  task automatic model_step();
    logic [WIDTH-1:0] p;
    bit trig;
    bit store;
    p    = bus.probe;
    trig = ((p & bus.trig_mask) == (bus.trig_value & bus.trig_mask));
    if (rst) begin
      m_state = 0; m_q.delete(); m_valid = 0; m_data = '0;
      m_rd_idx = 0; m_post = 0; m_first = 0; m_ts = 0;
    end else if (bus.clear) begin
      m_state = 0; m_q.delete(); m_valid = 0;
    end else if (bus.arm) begin
      m_state = 1; m_q.delete(); m_post = 0; m_first = 1;
      m_ts = 0; m_rd_idx = 0; m_valid = 0;
    end else begin
      m_valid = 0;
      if (m_state == 1 || m_state == 2) begin
        store = !bus.mode || m_first || (p != m_prev) || (m_state == 1 && trig);
        if (store) begin
          m_q.push_back(entry(m_ts, p));
          if (m_q.size() > DEPTH) void'(m_q.pop_front());
          if (m_state == 1) begin
            if (trig) begin
              m_post  = 1;
              m_state = (POST == 1) ? 3 : 2;
            end
          end else begin
            m_post++;
            if (m_post == POST) m_state = 3;
          end
        end
        m_first = 0;
        m_ts    = (m_ts + 1) % (1 << TS_W);
      end else if (m_state == 3 && bus.rd_req && m_rd_idx < m_q.size()) begin
        m_data  = m_q[m_rd_idx];
        m_valid = 1;
        m_rd_idx++;
      end
    end
    m_prev = p;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    bus.arm = 1'b0; bus.clear = 1'b0; bus.rd_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.probe      = WIDTH'($urandom);
      bus.arm        = 1'($urandom);
      bus.clear      = 1'($urandom);
      bus.mode       = 1'($urandom);
      bus.trig_mask  = WIDTH'($urandom);
      bus.trig_value = WIDTH'($urandom);
      bus.rd_req     = 1'($urandom);
      tick();
    end
    rst = 1'b0;
    quiet_inputs();
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.state); end
    checks++; if (bus.count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b want 0", bus.rd_valid); end
    checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h want 0", bus.rd_data); end
  endtask

  task automatic test_prepost_mode0();
    bus.mode = 1'b0; bus.trig_mask = 16'h00FF; bus.trig_value = 16'h0042;
    bus.probe = WIDTH'($urandom);
    bus.arm = 1'b1; tick(); bus.arm = 1'b0;
    for (int i = 0; i < 200 && bus.state != 2'd3; i++) begin
      bus.probe = WIDTH'(i);
      tick();
      checks++;
      if (bus.state !== 2'(m_state) || bus.count !== CW'(m_q.size())) begin
        errors++;
        $display("FAIL m0_track cyc %0d got state %0d count %0d want %0d %0d",
                 i, bus.state, bus.count, m_state, m_q.size());
      end
    end
    checks++; if (bus.state !== 2'd3) begin errors++; $display("FAIL m0_done got %0d want 3", bus.state); end
    checks++; if (bus.count !== CW'(8)) begin errors++; $display("FAIL m0_count got %0d want 8", bus.count); end
    for (int i = 0; i < 9; i++) begin
      bus.rd_req = 1'b1; tick();
      if (i < 8) begin
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== entry(16'h3E + i, WIDTH'(16'h3E + i))) begin
          errors++;
          $display("FAIL m0_read %0d got v=%b d=%h want v=1 d=%h", i, bus.rd_valid, bus.rd_data,
                   entry(16'h3E + i, WIDTH'(16'h3E + i)));
        end
      end else begin
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL m0_read_extra got v=%b want 0", bus.rd_valid); end
      end
    end
    bus.rd_req = 1'b0; tick();
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL m0_valid_drop got %b want 0", bus.rd_valid); end
    checks++; if (bus.count !== CW'(8)) begin errors++; $display("FAIL m0_count_hold got %0d want 8", bus.count); end
  endtask

  task automatic test_mode1();
    logic [WIDTH-1:0] seq [14];
    logic [WIDTH-1:0] expv [7];
    int               exp_ts [7];
    seq  = '{16'h11, 16'h11, 16'h22, 16'h22, 16'h22, 16'h33, 16'h42, 16'h42, 16'h42,
             16'h50, 16'h50, 16'h60, 16'h60, 16'h70};
    expv   = '{16'h11, 16'h22, 16'h33, 16'h42, 16'h50, 16'h60, 16'h70};
    exp_ts = '{0, 2, 5, 6, 9, 11, 13};
    bus.mode = 1'b1; bus.trig_mask = 16'h00FF; bus.trig_value = 16'h0042;
    bus.arm = 1'b1; tick(); bus.arm = 1'b0;
    for (int i = 0; i < 14; i++) begin
      bus.probe = seq[i];
      tick();
      checks++;
      if (bus.state !== 2'(m_state) || bus.count !== CW'(m_q.size())) begin
        errors++;
        $display("FAIL m1_track cyc %0d got state %0d count %0d want %0d %0d",
                 i, bus.state, bus.count, m_state, m_q.size());
      end
    end
    // Four distinct pre-trigger values plus three post-trigger changes.
    checks++; if (bus.state !== 2'd3) begin errors++; $display("FAIL m1_done got %0d want 3", bus.state); end
    checks++; if (bus.count !== CW'(7)) begin errors++; $display("FAIL m1_count got %0d want 7", bus.count); end
    for (int i = 0; i < 7; i++) begin
      bus.rd_req = 1'b1; tick();
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== entry(exp_ts[i], expv[i])) begin
        errors++;
        $display("FAIL m1_read %0d got v=%b d=%h want %h", i, bus.rd_valid, bus.rd_data, entry(exp_ts[i], expv[i]));
      end
    end
    bus.rd_req = 1'b0;
  endtask

  task automatic test_immediate();
    logic [WIDTH-1:0] probes [4];
    probes[0] = 16'h0042;
    for (int i = 1; i < 4; i++) probes[i] = WIDTH'($urandom);
    bus.mode = 1'b0; bus.trig_mask = 16'h00FF; bus.trig_value = 16'h0042;
    bus.arm = 1'b1; tick(); bus.arm = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.probe = probes[i];
      tick();
    end
    checks++; if (bus.state !== 2'd3) begin errors++; $display("FAIL imm_done got %0d want 3", bus.state); end
    checks++; if (bus.count !== CW'(4)) begin errors++; $display("FAIL imm_count got %0d want 4", bus.count); end
    for (int i = 0; i < 5; i++) begin
      bus.rd_req = 1'b1; tick();
      checks++;
      if (i < 4) begin
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== entry(i, probes[i])) begin
          errors++;
          $display("FAIL imm_read %0d got v=%b d=%h want %h", i, bus.rd_valid, bus.rd_data, entry(i, probes[i]));
        end
      end else if (bus.rd_valid !== 1'b0) begin
        errors++; $display("FAIL imm_read_extra got v=%b want 0", bus.rd_valid);
      end
    end
    bus.rd_req = 1'b0;
  endtask

  task automatic test_priority();
    bus.mode = 1'b0; bus.trig_mask = 16'h00FF; bus.trig_value = 16'h0042;
    bus.arm = 1'b1; tick(); bus.arm = 1'b0;
    bus.probe = 16'h0010;
    repeat (3) tick();
    checks++;
    if (bus.state !== 2'd1 || bus.count !== CW'(3)) begin
      errors++; $display("FAIL prio_armed got state %0d count %0d want 1 3", bus.state, bus.count);
    end
    bus.clear = 1'b1; bus.arm = 1'b1; tick(); quiet_inputs();
    checks++;
    if (bus.state !== 2'd0 || bus.count !== '0) begin
      errors++; $display("FAIL prio_clear_arm got state %0d count %0d want 0 0", bus.state, bus.count);
    end
    bus.arm = 1'b1; tick(); bus.arm = 1'b0;
    bus.probe = 16'h0042; tick();
    bus.probe = 16'h0001; tick();
    checks++;
    if (bus.state !== 2'd2 || bus.count !== CW'(2)) begin
      errors++; $display("FAIL prio_capture got state %0d count %0d want 2 2", bus.state, bus.count);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if (bus.state !== 2'd0 || bus.count !== '0) begin
      errors++; $display("FAIL prio_rst got state %0d count %0d want 0 0", bus.state, bus.count);
    end
    bus.rd_req = 1'b1; tick(); bus.rd_req = 1'b0;
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL prio_rd_after_rst got v=%b want 0", bus.rd_valid); end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      rst       = ($urandom_range(0, 599) == 0);
      bus.clear = ($urandom_range(0, 149) == 0);
      bus.arm   = ($urandom_range(0, 39) == 0);
      if (bus.arm) begin
        bus.mode       = 1'($urandom);
        bus.trig_mask  = WIDTH'($urandom_range(0, 15));
        bus.trig_value = WIDTH'($urandom_range(0, 15));
      end
      bus.probe  = ($urandom_range(0, 3) == 0) ? bus.probe : WIDTH'($urandom_range(0, 15));
      bus.rd_req = 1'($urandom);
      tick();
      checks++;
      if (bus.state !== 2'(m_state) || bus.count !== CW'(m_q.size()) ||
          bus.rd_valid !== m_valid || bus.rd_data !== m_data) begin
        errors++;
        $display("FAIL rand cyc %0d got st=%0d cnt=%0d v=%b d=%h want st=%0d cnt=%0d v=%b d=%h",
                 cyc, bus.state, bus.count, bus.rd_valid, bus.rd_data,
                 m_state, m_q.size(), m_valid, m_data);
      end
    end
    rst = 1'b0;
    quiet_inputs();
  endtask

  initial begin
    test_reset();
    test_prepost_mode0();
    test_mode1();
    test_immediate();
    test_priority();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
